// File: rtl/segmenter_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : segmenter_rr_scheduler
// Purpose  : Message-granular round-robin scheduler. It shares one segmenter
//            input stream among N requester AXI streams. A grant is held from
//            the first beat of a message through its tlast beat.
// Revision : 1.0 - initial release
// ============================================================================
module segmenter_rr_scheduler #(
  parameter int N         = 4,
  parameter int DATA_W    = 128,
  parameter int MAX_BEATS = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req_en,
  input  logic [N*DATA_W-1:0]     s_axis_tdata,
  input  logic [N-1:0]            s_axis_tvalid,
  input  logic [N-1:0]            s_axis_tlast,
  output logic [N-1:0]            s_axis_tready,
  output logic [DATA_W-1:0]       m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [$clog2(N)-1:0]    m_axis_tid,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    err_overlong,
  output logic [$clog2(N)-1:0]    err_qp
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant;
  logic [CNT_W-1:0]  beat_cnt;

  logic [N-1:0]      cand;
  logic              found;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W:0]    scan_idx;
  logic              sel_valid;
  logic              accept;
  logic [DATA_W-1:0] lane [N];

  // Split the flat requester data bus into one lane per requester.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign lane[gi] = s_axis_tdata[gi*DATA_W +: DATA_W];
  end

  assign cand = s_axis_tvalid & req_en;

  // Pick the first enabled, valid requester scanning upward from rr_ptr.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan_idx >= N_EXT) begin
        scan_idx = scan_idx - N_EXT;
      end
      if (!found && cand[scan_idx[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[IDX_W-1:0];
      end
    end
  end

  // The granted stream goes straight through; everything is zero when not valid.
  assign sel_valid     = (state == XFER) && s_axis_tvalid[grant];
  assign accept        = sel_valid && m_axis_tready;
  assign m_axis_tvalid = sel_valid;
  assign m_axis_tdata  = sel_valid ? lane[grant] : '0;
  assign m_axis_tlast  = sel_valid ? s_axis_tlast[grant] : 1'b0;
  assign m_axis_tid    = sel_valid ? grant : '0;
  assign busy          = (state == XFER);

  // Only the granted requester sees the segmenter's ready, and only in XFER.
  always_comb begin
    s_axis_tready = '0;
    if (state == XFER) begin
      s_axis_tready[grant] = m_axis_tready;
    end
  end

  // Arbitration / transfer state machine with beat counting and error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      beat_cnt     <= '0;
      err_overlong <= 1'b0;
      err_qp       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= winner;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            if (beat_cnt != CNT_MAX) begin
              beat_cnt <= beat_cnt + 1'b1;
            end
            // Only the first over-length event is recorded; the message still flows.
            if (!s_axis_tlast[grant] && (beat_cnt == LAST_CNT) && !err_overlong) begin
              err_overlong <= 1'b1;
              err_qp       <= grant;
            end
            if (s_axis_tlast[grant]) begin
              state  <= IDLE;
              rr_ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_segmenter_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_segmenter_rr_scheduler
// Purpose  : Self-checking bench: directed vector table, hand-written corner
//            sequences and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segmenter_rr_scheduler;

  localparam int N      = 4;
  localparam int DW     = 32;
  localparam int MAXB   = 4;
  localparam int CNTMAX = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_en;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tlast;
  logic [N-1:0]    s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic [1:0]      m_axis_tid;
  logic            m_axis_tready;
  logic            busy;
  logic            err_overlong;
  logic [1:0]      err_qp;

  segmenter_rr_scheduler #(.N(N), .DATA_W(DW), .MAX_BEATS(MAXB)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_en        (req_en),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .err_overlong  (err_overlong),
    .err_qp        (err_qp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Upstream drivers: beats left in the current message and a per-lane beat id.
  int          left [N];
  logic [23:0] beat_id [N];
  int          len_mode  = 0;
  int          fixed_len = 2;

  // Reference model: who owns the output, rotation pointer, beats so far, errors.
  bit md_xfer;
  int md_grant, md_ptr, md_cnt;
  bit md_err;
  int md_qp;

  logic       cur_rst, cur_mr;
  logic [3:0] cur_en, cur_v, cur_l;

  int done_q[$];
  int beat_count [N];

  typedef struct {
    bit       r;
    bit [3:0] en, v, l;
    bit       mr;
    bit       e_mv, e_ml;
    bit [1:0] e_tid;
    bit       e_busy;
    bit [3:0] e_str;
  } vec_t;

  vec_t tbl [27];

  function automatic vec_t mk(bit r, bit [3:0] en, bit [3:0] v, bit [3:0] l, bit mr,
                              bit e_mv, bit e_ml, bit [1:0] e_tid, bit e_busy, bit [3:0] e_str);
    vec_t t;
    t.r = r; t.en = en; t.v = v; t.l = l; t.mr = mr;
    t.e_mv = e_mv; t.e_ml = e_ml; t.e_tid = e_tid; t.e_busy = e_busy; t.e_str = e_str;
    return t;
  endfunction

  function automatic logic [DW-1:0] lane(int i);
    return {8'(i), beat_id[i]};
  endfunction

  function automatic int newlen();
    return (len_mode != 0) ? int'($urandom_range(1, 6)) : fixed_len;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then compare the DUT against the model mid-cycle.
  task automatic apply(input bit r, input logic [3:0] en, input logic [3:0] v,
                       input logic [3:0] l, input bit mr);
    logic [3:0]    e_str;
    logic          e_mv, e_ml;
    logic [DW-1:0] e_data;
    int            e_tid;
    rst = r; req_en = en; s_axis_tvalid = v; s_axis_tlast = l; m_axis_tready = mr;
    for (int i = 0; i < N; i++) s_axis_tdata[i*DW +: DW] = lane(i);
    cur_rst = r; cur_en = en; cur_v = v; cur_l = l; cur_mr = mr;
    #2;
    e_str = '0;
    if (md_xfer) e_str[md_grant] = mr;
    e_mv   = md_xfer && v[md_grant];
    e_ml   = e_mv && l[md_grant];
    e_tid  = e_mv ? md_grant : 0;
    e_data = e_mv ? lane(md_grant) : '0;
    chk("m_tvalid", 32'(m_axis_tvalid), 32'(e_mv));
    chk("m_tlast", 32'(m_axis_tlast), 32'(e_ml));
    chk("m_tid", 32'(m_axis_tid), 32'(e_tid));
    chk("m_tdata", m_axis_tdata, e_data);
    chk("busy", 32'(busy), 32'(md_xfer));
    chk("s_tready", 32'(s_axis_tready), 32'(e_str));
    chk("err_overlong", 32'(err_overlong), 32'(md_err));
    chk("err_qp", 32'(err_qp), 32'(md_qp));
    if (m_axis_tvalid && m_axis_tready) begin
      beat_count[m_axis_tid]++;
      if (m_axis_tlast) done_q.push_back(int'(m_axis_tid));
    end
  endtask

  // Step the model by the rules of the scheduler, then cross the clock edge.
  task automatic advance();
    logic [3:0] acc;
    bit         f;
    int         idx, g;
    acc = '0;
    f   = 1'b0;
    if (cur_rst) begin
      md_xfer = 0; md_grant = 0; md_ptr = 0; md_cnt = 0; md_err = 0; md_qp = 0;
      for (int i = 0; i < N; i++) left[i] = newlen();
    end else if (!md_xfer) begin
      for (int k = 0; k < N; k++) begin
        idx = (md_ptr + k) % N;
        if (!f && cur_v[idx] && cur_en[idx]) begin
          f = 1'b1;
          md_grant = idx;
        end
      end
      if (f) begin
        md_xfer = 1;
        md_cnt  = 0;
      end
    end else if (cur_v[md_grant] && cur_mr) begin
      g = md_grant;
      acc[g] = 1'b1;
      if (!cur_l[g] && md_cnt == MAXB - 1 && !md_err) begin
        md_err = 1;
        md_qp  = g;
      end
      if (md_cnt < CNTMAX) md_cnt++;
      if (cur_l[g]) begin
        md_xfer = 0;
        md_ptr  = (g + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        beat_id[i] = beat_id[i] + 24'd1;
        if (cur_l[i]) left[i] = newlen();
        else if (left[i] > 1) left[i]--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // One cycle of driver-generated traffic: tlast marks each message's final beat.
  task automatic auto_cyc(input bit r, input logic [3:0] en, input int vprob, input bit mr);
    logic [3:0] v, l;
    for (int i = 0; i < N; i++) begin
      v[i] = ($urandom_range(0, 99) < vprob);
      l[i] = (left[i] == 1);
    end
    apply(r, en, v, l, mr);
    advance();
  endtask

  // Test sequence: vector table, corner-case sequences, then random traffic.
  initial begin
    rst = 1'b1; req_en = '0; s_axis_tdata = '0; s_axis_tvalid = '0;
    s_axis_tlast = '0; m_axis_tready = 1'b0;
    for (int i = 0; i < N; i++) begin
      left[i] = 2; beat_id[i] = 24'(i * 24'h100); beat_count[i] = 0;
    end
    md_xfer = 0; md_grant = 0; md_ptr = 0; md_cnt = 0; md_err = 0; md_qp = 0;
    repeat (2) @(posedge clk);
    #1;

    //             r  en    v     l     mr  mv ml tid busy str
    tbl[0]  = mk(1, 4'hF, 4'h0, 4'h0, 0,  0, 0, 0, 0, 4'h0);
    tbl[1]  = mk(0, 4'hF, 4'h4, 4'h0, 1,  0, 0, 0, 0, 4'h0);
    tbl[2]  = mk(0, 4'hF, 4'h4, 4'h0, 1,  1, 0, 2, 1, 4'h4);
    tbl[3]  = mk(0, 4'hF, 4'h4, 4'h0, 1,  1, 0, 2, 1, 4'h4);
    tbl[4]  = mk(0, 4'hF, 4'h4, 4'h4, 1,  1, 1, 2, 1, 4'h4);
    tbl[5]  = mk(0, 4'hF, 4'h0, 4'h0, 1,  0, 0, 0, 0, 4'h0);
    tbl[6]  = mk(0, 4'hF, 4'hF, 4'h0, 1,  0, 0, 0, 0, 4'h0);
    tbl[7]  = mk(0, 4'hF, 4'hF, 4'hF, 1,  1, 1, 3, 1, 4'h8);
    tbl[8]  = mk(0, 4'hF, 4'h0, 4'h0, 1,  0, 0, 0, 0, 4'h0);
    tbl[9]  = mk(0, 4'hF, 4'h2, 4'h0, 1,  0, 0, 0, 0, 4'h0);
    tbl[10] = mk(0, 4'hF, 4'h2, 4'h0, 1,  1, 0, 1, 1, 4'h2);
    tbl[11] = mk(0, 4'hF, 4'h2, 4'h0, 0,  1, 0, 1, 1, 4'h0);
    tbl[12] = mk(0, 4'hF, 4'h2, 4'h0, 1,  1, 0, 1, 1, 4'h2);
    tbl[13] = mk(0, 4'hF, 4'h2, 4'h0, 0,  1, 0, 1, 1, 4'h0);
    tbl[14] = mk(0, 4'hF, 4'h2, 4'h0, 1,  1, 0, 1, 1, 4'h2);
    tbl[15] = mk(0, 4'hF, 4'h2, 4'h0, 0,  1, 0, 1, 1, 4'h0);
    tbl[16] = mk(0, 4'hF, 4'h2, 4'h2, 1,  1, 1, 1, 1, 4'h2);
    tbl[17] = mk(0, 4'hF, 4'h0, 4'h0, 1,  0, 0, 0, 0, 4'h0);
    tbl[18] = mk(0, 4'hF, 4'h1, 4'h0, 1,  0, 0, 0, 0, 4'h0);
    tbl[19] = mk(0, 4'hF, 4'h0, 4'h0, 1,  0, 0, 0, 1, 4'h1);
    tbl[20] = mk(0, 4'hF, 4'h1, 4'h1, 1,  1, 1, 0, 1, 4'h1);
    tbl[21] = mk(0, 4'hF, 4'hF, 4'h0, 1,  0, 0, 0, 0, 4'h0);
    tbl[22] = mk(0, 4'hF, 4'hF, 4'h0, 1,  1, 0, 1, 1, 4'h2);
    tbl[23] = mk(1, 4'hF, 4'hF, 4'h0, 1,  1, 0, 1, 1, 4'h2);
    tbl[24] = mk(0, 4'hF, 4'h0, 4'h0, 1,  0, 0, 0, 0, 4'h0);
    tbl[25] = mk(0, 4'hF, 4'hF, 4'h0, 1,  0, 0, 0, 0, 4'h0);
    tbl[26] = mk(0, 4'hF, 4'hF, 4'hF, 1,  1, 1, 0, 1, 4'h1);

    for (int k = 0; k < 27; k++) begin
      apply(tbl[k].r, tbl[k].en, tbl[k].v, tbl[k].l, tbl[k].mr);
      chk($sformatf("tbl%0d_mvalid", k), 32'(m_axis_tvalid), 32'(tbl[k].e_mv));
      chk($sformatf("tbl%0d_mlast", k), 32'(m_axis_tlast), 32'(tbl[k].e_ml));
      chk($sformatf("tbl%0d_tid", k), 32'(m_axis_tid), 32'(tbl[k].e_tid));
      chk($sformatf("tbl%0d_data", k), m_axis_tdata,
          tbl[k].e_mv ? lane(int'(tbl[k].e_tid)) : '0);
      chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].e_busy));
      chk($sformatf("tbl%0d_stready", k), 32'(s_axis_tready), 32'(tbl[k].e_str));
      chk($sformatf("tbl%0d_err", k), 32'(err_overlong), 32'd0);
      advance();
    end

    // All requesters valid, 2-beat messages: grants rotate 0,1,2,3,0.
    len_mode = 0; fixed_len = 2;
    auto_cyc(1, 4'hF, 100, 1);
    done_q.delete();
    repeat (16) auto_cyc(0, 4'hF, 100, 1);
    chk("rr_count", 32'(done_q.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k < done_q.size()) chk($sformatf("rr_order%0d", k), 32'(done_q[k]), 32'(k % 4));
    end

    // Requester 2 disabled: it must never be granted.
    len_mode = 1;
    done_q.delete();
    for (int i = 0; i < N; i++) beat_count[i] = 0;
    repeat (150) auto_cyc(0, 4'b1011, 70, 1'($urandom_range(0, 1)));
    chk("en_skip_2", 32'(beat_count[2]), 32'd0);
    chk("en_progress", 32'(done_q.size() > 0), 32'd1);

    // Disabling the granted requester mid-message does not cut the message.
    len_mode = 0; fixed_len = 3;
    auto_cyc(1, 4'hF, 100, 1);
    auto_cyc(0, 4'hF, 100, 1);
    auto_cyc(0, 4'hF, 100, 1);
    done_q.delete();
    repeat (3) auto_cyc(0, 4'b1110, 100, 1);
    chk("en_clear_done", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) chk("en_clear_tid", 32'(done_q[0]), 32'd0);

    // Over-length: requester 1 sends 6 beats with a 4-beat limit.
    fixed_len = 6;
    auto_cyc(1, 4'hF, 100, 1);
    for (int i = 0; i < N; i++) beat_count[i] = 0;
    repeat (4) auto_cyc(0, 4'b0010, 100, 1);
    chk("ovl_before", 32'(err_overlong), 32'd0);
    auto_cyc(0, 4'b0010, 100, 1);
    chk("ovl_set", 32'(err_overlong), 32'd1);
    chk("ovl_qp", 32'(err_qp), 32'd1);
    repeat (2) auto_cyc(0, 4'b0010, 100, 1);
    chk("ovl_all_beats", 32'(beat_count[1]), 32'd6);
    left[0] = 2;
    repeat (4) auto_cyc(0, 4'b0001, 100, 1);
    chk("ovl_legal_done", 32'(beat_count[0]), 32'd2);
    chk("ovl_sticky", 32'(err_overlong), 32'd1);
    chk("ovl_qp_sticky", 32'(err_qp), 32'd1);
    auto_cyc(1, 4'hF, 100, 1);
    chk("ovl_rst_err", 32'(err_overlong), 32'd0);
    chk("ovl_rst_qp", 32'(err_qp), 32'd0);
    chk("ovl_rst_busy", 32'(busy), 32'd0);

    // Randomized traffic against the model.
    len_mode = 1;
    auto_cyc(1, 4'hF, 100, 1);
    for (int c = 0; c < 3000; c++) begin
      auto_cyc(($urandom_range(0, 499) == 0),
               ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
               60, ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/segmenter_rr_scheduler.md
Name: segmenter_rr_scheduler

Overview:
- Shares one packet segmenter input stream among N requester streams (one per queue pair).
- Uses message-granular round-robin arbitration: a grant is held from the first beat through the tlast beat, so segmenter traffic is never interleaved.
- Presents the winner's stream on a single AXI-stream master that drives the segmenter's s_axis side, tagged with the requester index.
- Provides a per-requester enable mask and a sticky over-length error for configuration and monitoring.

Parameters:
- N, 4, number of requesters; must be at least 2.
- DATA_W, 128, stream data width; equals the segmenter input frame width.
- MAX_BEATS, 64, longest legal message in beats; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_en  in  N  per-requester enable; sampled only during arbitration.
- s_axis_tdata  in  N*DATA_W  requester data; requester i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tvalid  in  N  per-requester valid.
- s_axis_tlast  in  N  per-requester end of message.
- s_axis_tready  out  N  per-requester ready.
- m_axis_tdata  out  DATA_W  data to the segmenter.
- m_axis_tvalid  out  1  valid to the segmenter.
- m_axis_tlast  out  1  end of message.
- m_axis_tid  out  clog2(N)  index of the granted requester.
- m_axis_tready  in  1  segmenter ready.
- busy  out  1  high while in XFER.
- err_overlong  out  1  sticky over-length error flag.
- err_qp  out  clog2(N)  requester that caused the first over-length error.

Behaviour:
- State machine has two states, IDLE and XFER. Reset puts it in IDLE.
- Reset values: rr_ptr=0, grant=0, beat_cnt=0, busy=0, err_overlong=0, err_qp=0, all s_axis_tready=0, m_axis_tvalid=0. m_axis_tdata, m_axis_tlast and m_axis_tid are zero when tvalid=0.
- IDLE:
  - Candidates are requesters with s_axis_tvalid[i] & req_en[i].
  - The winner is the first candidate found scanning from rr_ptr upward, modulo N.
  - If a winner exists: at the next edge grant<=winner, beat_cnt<=0, state<=XFER.
  - No data is accepted in IDLE, and every s_axis_tready is 0. Arbitration therefore costs exactly one cycle per message.
- XFER:
  - m_axis_tvalid=s_axis_tvalid[grant], m_axis_tdata=the grant slice, m_axis_tlast=s_axis_tlast[grant], m_axis_tid=grant.
  - These paths are combinational, with zero latency.
  - s_axis_tready[grant]=m_axis_tready; all other s_axis_tready are 0.
  - A beat is accepted when m_axis_tvalid & m_axis_tready; each accepted beat does beat_cnt<=beat_cnt+1.
  - Accepted beat with tlast: state<=IDLE and rr_ptr<=grant+1, wrapping to 0 when grant=N-1.
  - The next arbitration happens in the following IDLE cycle, so there is one bubble between back-to-back messages.
- Fairness: the last winner has the lowest priority. With all N requesters continuously valid, grants rotate 0,1,...,N-1,0.
- req_en:
  - Deasserting the granted requester's bit mid-message does not abort the message; the grant is held until its tlast.
  - Disabled requesters are skipped in IDLE.
- Stalls: a granted requester with tvalid low holds the grant indefinitely (no timeout). m_axis_tvalid stays low and beat_cnt holds.
- Over-length:
  - If a beat is accepted without tlast while beat_cnt==MAX_BEATS-1, set err_overlong.
  - On the first such event, capture err_qp=grant. err_overlong stays set and err_qp is unchanged until reset.
  - Data flow is unaffected: the message continues until its tlast.
- beat_cnt is clog2(MAX_BEATS)+1 bits wide and saturates at its maximum value.
- Reset mid-message: state returns to IDLE and the grant is dropped immediately. The partial message is not terminated; upstream must also reset.
- A single-beat message (tlast on the first beat) is legal: one beat is accepted in XFER, then IDLE.

Test Plan:
- N=4, only requester 2 valid with a 3-beat message (D0,D1,D2, tlast on D2) and m_tready=1 -> 1 idle cycle, then m_tid=2 with D0,D1,D2 on consecutive cycles; m_tlast only with D2; busy falls the next cycle; rr_ptr=3.
- All 4 requesters continuously valid with 2-beat messages -> grant order 0,1,2,3,0; each message is 2 beats plus 1 bubble; no interleaving of m_tid within a message.
- m_tready toggles 1,0,1,0 during a 4-beat message -> 4 beats delivered in order; s_tready[grant] mirrors m_tready; other s_tready are 0 throughout.
- req_en=4'b1011 with all requesters valid -> requester 2 is never granted. Clearing req_en[0] mid-message from requester 0 -> its message completes with tlast.
- MAX_BEATS=4 and requester 1 sends 6 beats -> err_overlong rises after the 4th beat without tlast; err_qp=1; all 6 beats pass; the flag stays set through later legal messages until rst.
- Assert rst during beat 2 of a 5-beat message -> next cycle m_tvalid=0, busy=0, all s_tready=0, rr_ptr=0, errors cleared.
